// File: rtl/mips_pkg.sv
// Shared definitions for the MIPS fetch front end: vectors, bubble word, FSM and next-PC encodings.
package mips_pkg;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned WORD_BYTES = 4;

  localparam logic [XLEN-1:0] DEF_RESET_VEC = 32'h0000_0000;
  localparam logic [XLEN-1:0] DEF_IRQ_VEC   = 32'h0000_0004;
  localparam logic [XLEN-1:0] DEF_EXC_VEC   = 32'h0000_0008;
  localparam logic [XLEN-1:0] DEF_NOP_WORD  = 32'h0000_0000;

  // Sequencer phase: BOOT fetches word 0 once, TRAP is the single bubble slot after vectoring.
  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_TRAP = 2'd2
  } seq_state_e;

  // Source of the next PC, ordered loosely by how disruptive it is.
  typedef enum logic [2:0] {
    SEL_SEQ    = 3'd0,
    SEL_HOLD   = 3'd1,
    SEL_BRANCH = 3'd2,
    SEL_JUMP   = 3'd3,
    SEL_JR     = 3'd4,
    SEL_ERET   = 3'd5,
    SEL_IRQ    = 3'd6,
    SEL_EXC    = 3'd7
  } npc_sel_e;

  // IF/ID pipeline register payload.
  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc4;
    logic            valid;
  } if_id_t;

  // Instruction fetches are word aligned; low address bits of any target are dropped.
  function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_sequencer_npc_mux.sv
// Next-PC priority selector with target alignment for the fetch sequencer.
module npc_mux
  import mips_pkg::*;
#(
  parameter logic [XLEN-1:0] IRQ_VEC = DEF_IRQ_VEC,
  parameter logic [XLEN-1:0] EXC_VEC = DEF_EXC_VEC
) (
  input  seq_state_e       state,
  input  logic             kernel_mode,
  input  logic             stall,
  input  logic             branch_taken,
  input  logic [XLEN-1:0]  branch_target,
  input  logic             jump,
  input  logic [XLEN-1:0]  jump_target,
  input  logic             jr,
  input  logic [XLEN-1:0]  jr_target,
  input  logic             eret,
  input  logic             irq,
  input  logic             exception,
  input  logic [XLEN-1:0]  pc,
  input  logic [XLEN-1:0]  epc,
  output npc_sel_e         sel,
  output logic [XLEN-1:0]  npc,
  output logic [XLEN-1:0]  redirect_pc,
  output logic             redirect_hit
);

  // Priority decision; BOOT always fetches sequentially, TRAP only honours a new exception.
  always_comb begin
    sel = SEL_SEQ;
    if (state == ST_BOOT) begin
      sel = SEL_SEQ;
    end else if (exception) begin
      sel = SEL_EXC;
    end else if (state == ST_RUN) begin
      if (irq && !kernel_mode)     sel = SEL_IRQ;
      else if (eret && kernel_mode) sel = SEL_ERET;
      else if (jr)                  sel = SEL_JR;
      else if (jump)                sel = SEL_JUMP;
      else if (branch_taken)        sel = SEL_BRANCH;
      else if (stall)               sel = SEL_HOLD;
      else                          sel = SEL_SEQ;
    end
  end

  // Highest-priority control-flow target raised by ID, used as the resume point if an irq lands on it.
  always_comb begin
    redirect_hit = jr | jump | branch_taken;
    redirect_pc  = align_word(branch_target);
    if (jr)        redirect_pc = align_word(jr_target);
    else if (jump) redirect_pc = align_word(jump_target);
  end

  // Next-PC value for the chosen source.
  always_comb begin
    npc = pc + XLEN'(WORD_BYTES);
    case (sel)
      SEL_SEQ:    npc = pc + XLEN'(WORD_BYTES);
      SEL_HOLD:   npc = pc;
      SEL_BRANCH: npc = align_word(branch_target);
      SEL_JUMP:   npc = align_word(jump_target);
      SEL_JR:     npc = align_word(jr_target);
      SEL_ERET:   npc = align_word(epc);
      SEL_IRQ:    npc = align_word(IRQ_VEC);
      SEL_EXC:    npc = align_word(EXC_VEC);
      default:    npc = pc + XLEN'(WORD_BYTES);
    endcase
  end

endmodule

// File: rtl/fetch_sequencer.sv
// PC sequencer and IF/ID register for the 5-stage MIPS pipeline; sole driver of the IMEM address.
module fetch_sequencer
  import mips_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_VEC = DEF_RESET_VEC,
  parameter logic [XLEN-1:0] IRQ_VEC   = DEF_IRQ_VEC,
  parameter logic [XLEN-1:0] EXC_VEC   = DEF_EXC_VEC,
  parameter logic [XLEN-1:0] NOP_WORD  = DEF_NOP_WORD
) (
  input  logic             clk,
  input  logic             reset,
  output logic [XLEN-1:0]  imem_addr,
  input  logic [XLEN-1:0]  imem_rdata,
  input  logic             stall,
  input  logic             branch_taken,
  input  logic [XLEN-1:0]  branch_target,
  input  logic             jump,
  input  logic [XLEN-1:0]  jump_target,
  input  logic             jr,
  input  logic [XLEN-1:0]  jr_target,
  input  logic             eret,
  input  logic             irq,
  input  logic             exception,
  output logic [XLEN-1:0]  if_id_instr,
  output logic [XLEN-1:0]  if_id_pc4,
  output logic             if_id_valid,
  output logic             flush_id,
  output logic             kernel_mode,
  output logic [XLEN-1:0]  epc
);

  seq_state_e       state;
  if_id_t           if_id;
  npc_sel_e         sel;
  logic [XLEN-1:0]  npc;
  logic [XLEN-1:0]  redirect_pc;
  logic             redirect_hit;
  if_id_t           bubble;

  npc_mux #(
    .IRQ_VEC (IRQ_VEC),
    .EXC_VEC (EXC_VEC)
  ) u_npc_mux (
    .state         (state),
    .kernel_mode   (kernel_mode),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .jump          (jump),
    .jump_target   (jump_target),
    .jr            (jr),
    .jr_target     (jr_target),
    .eret          (eret),
    .irq           (irq),
    .exception     (exception),
    .pc            (imem_addr),
    .epc           (epc),
    .sel           (sel),
    .npc           (npc),
    .redirect_pc   (redirect_pc),
    .redirect_hit  (redirect_hit)
  );

  // A squashed slot carries the address now being fetched (as pc4) so an irq landing on the
  // bubble resumes at that instruction rather than at a stale return address.
  assign bubble = '{instr: NOP_WORD, pc4: npc + XLEN'(WORD_BYTES), valid: 1'b0};

  // ID squashes its instruction only when a trap is taken this cycle.
  assign flush_id = ~reset & ((sel == SEL_EXC) | (sel == SEL_IRQ));

  assign if_id_instr = if_id.instr;
  assign if_id_pc4   = if_id.pc4;
  assign if_id_valid = if_id.valid;

  // Sequencer FSM, PC, IF/ID, kernel mode and EPC update.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_BOOT;
      imem_addr   <= RESET_VEC;
      if_id       <= '{instr: NOP_WORD, pc4: '0, valid: 1'b0};
      kernel_mode <= 1'b1;
      epc         <= '0;
    end else begin
      imem_addr <= npc;
      case (sel)
        SEL_HOLD: begin
          // load-use stall: everything holds
        end
        SEL_SEQ: begin
          if_id <= '{instr: imem_rdata, pc4: imem_addr + XLEN'(WORD_BYTES), valid: 1'b1};
          state <= ST_RUN;
        end
        SEL_EXC: begin
          epc         <= if_id.pc4;
          kernel_mode <= 1'b1;
          if_id       <= bubble;
          state       <= ST_TRAP;
        end
        SEL_IRQ: begin
          epc         <= redirect_hit ? redirect_pc : if_id.pc4 - XLEN'(WORD_BYTES);
          kernel_mode <= 1'b1;
          if_id       <= bubble;
          state       <= ST_TRAP;
        end
        SEL_ERET: begin
          kernel_mode <= 1'b0;
          if_id       <= bubble;
        end
        default: begin
          if_id <= bubble;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: directed scenarios followed by random control traffic,
// all checked against an architectural model of PC / IF-ID / kernel-mode behaviour.
module tb_fetch_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        stall, branch_taken, jump, jr, eret, irq, exception;
  logic [31:0] branch_target, jump_target, jr_target;
  logic [31:0] if_id_instr, if_id_pc4, epc;
  logic        if_id_valid, flush_id, kernel_mode;

  int n_cmp = 0;
  int n_err = 0;

  // architectural model state
  logic [31:0] m_pc, m_instr, m_pc4, m_epc;
  logic        m_valid, m_kernel, m_boot, m_trap;

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  function automatic logic [31:0] align(input logic [31:0] a);
    return a & 32'hFFFF_FFFC;
  endfunction

  assign imem_rdata = mem_word(imem_addr);

  fetch_sequencer dut (
    .clk           (clk),
    .reset         (reset),
    .imem_addr     (imem_addr),
    .imem_rdata    (imem_rdata),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .jump          (jump),
    .jump_target   (jump_target),
    .jr            (jr),
    .jr_target     (jr_target),
    .eret          (eret),
    .irq           (irq),
    .exception     (exception),
    .if_id_instr   (if_id_instr),
    .if_id_pc4     (if_id_pc4),
    .if_id_valid   (if_id_valid),
    .flush_id      (flush_id),
    .kernel_mode   (kernel_mode),
    .epc           (epc)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    reset = 1'b0; stall = 1'b0; branch_taken = 1'b0; jump = 1'b0; jr = 1'b0;
    eret = 1'b0; irq = 1'b0; exception = 1'b0;
    branch_target = '0; jump_target = '0; jr_target = '0;
  endtask

  // IF/ID receives the word at the current PC and fetch moves on.
  task automatic m_fetch();
    m_instr = mem_word(m_pc);
    m_pc4   = m_pc + 32'd4;
    m_valid = 1'b1;
    m_pc    = m_pc + 32'd4;
  endtask

  // Fetch is redirected; the in-flight word is discarded, the slot remembers where fetch resumes.
  task automatic m_squash(input logic [31:0] target);
    m_pc    = target;
    m_instr = 32'h0;
    m_pc4   = target + 32'd4;
    m_valid = 1'b0;
  endtask

  function automatic logic exp_flush();
    return !reset && !m_boot && (exception || (!m_trap && irq && !m_kernel));
  endfunction

  // One clock of architectural behaviour, evaluated on the values seen at the edge.
  task automatic model_tick();
    logic [31:0] resume;
    if (reset) begin
      m_pc = 32'h0; m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
      m_kernel = 1'b1; m_epc = 32'h0; m_boot = 1'b1; m_trap = 1'b0;
    end else if (m_boot) begin
      m_fetch();
      m_boot = 1'b0;
    end else if (exception) begin
      m_epc = m_pc4; m_kernel = 1'b1; m_squash(32'h8); m_trap = 1'b1;
    end else if (m_trap) begin
      m_fetch();
      m_trap = 1'b0;
    end else if (irq && !m_kernel) begin
      if (jr)                resume = align(jr_target);
      else if (jump)         resume = align(jump_target);
      else if (branch_taken) resume = align(branch_target);
      else                   resume = m_pc4 - 32'd4;
      m_epc = resume; m_kernel = 1'b1; m_squash(32'h4); m_trap = 1'b1;
    end else if (eret && m_kernel) begin
      m_kernel = 1'b0; m_squash(align(m_epc));
    end else if (jr) begin
      m_squash(align(jr_target));
    end else if (jump) begin
      m_squash(align(jump_target));
    end else if (branch_taken) begin
      m_squash(align(branch_target));
    end else if (!stall) begin
      m_fetch();
    end
  endtask

  task automatic check_all();
    chk("imem_addr",   imem_addr,          m_pc);
    chk("if_id_instr", if_id_instr,        m_instr);
    chk("if_id_pc4",   if_id_pc4,          m_pc4);
    chk("if_id_valid", 32'(if_id_valid),   32'(m_valid));
    chk("kernel_mode", 32'(kernel_mode),   32'(m_kernel));
    chk("epc",         epc,                m_epc);
  endtask

  // Called just after a falling edge with inputs already driven.
  task automatic step();
    #1;
    chk("flush_id", 32'(flush_id), 32'(exp_flush()));
    @(posedge clk);
    model_tick();
    #1;
    check_all();
    @(negedge clk);
  endtask

  initial begin
    m_pc = '0; m_instr = '0; m_pc4 = '0; m_epc = '0;
    m_valid = 1'b0; m_kernel = 1'b1; m_boot = 1'b1; m_trap = 1'b0;
    idle();
    reset = 1'b1;
    exception = 1'b1;
    irq = 1'b1;
    @(negedge clk);

    // reset held two cycles; flush stays low despite trap requests
    step();
    step();
    chk("reset_addr", imem_addr, 32'h0);
    chk("reset_valid", 32'(if_id_valid), 32'h0);
    chk("reset_kernel", 32'(kernel_mode), 32'h1);

    // BOOT cycle fetches word 0
    idle();
    step();
    chk("boot_addr", imem_addr, 32'h4);
    chk("boot_pc4", if_id_pc4, 32'h4);
    chk("boot_instr", if_id_instr, mem_word(32'h0));

    // leave kernel mode: eret returns to epc=0
    eret = 1'b1;
    step();
    chk("eret0_kernel", 32'(kernel_mode), 32'h0);
    chk("eret0_addr", imem_addr, 32'h0);
    idle();
    step(); step(); step();
    chk("seq_addr_c", imem_addr, 32'hC);

    // jump at PC=0x0C to 0x38
    jump = 1'b1; jump_target = 32'h38;
    step();
    chk("jump_addr", imem_addr, 32'h38);
    chk("jump_bubble", 32'(if_id_valid), 32'h0);
    idle();
    step();
    chk("jump_valid", 32'(if_id_valid), 32'h1);
    chk("jump_instr", if_id_instr, mem_word(32'h38));

    // stall two cycles at PC=0x10
    jump = 1'b1; jump_target = 32'hC;
    step();
    idle();
    step();
    stall = 1'b1;
    step(); step();
    chk("stall_addr", imem_addr, 32'h10);
    chk("stall_pc4", if_id_pc4, 32'h10);
    stall = 1'b0;
    step();
    chk("unstall_addr", imem_addr, 32'h14);

    // stall together with taken branch: redirect wins
    stall = 1'b1; branch_taken = 1'b1; branch_target = 32'hC;
    step();
    chk("stall_branch_addr", imem_addr, 32'hC);
    idle();
    step(); step(); step();
    chk("pre_irq_pc4", if_id_pc4, 32'h18);

    // irq with ID pc4=0x18, held through handler entry
    irq = 1'b1;
    #1 chk("irq_flush", 32'(flush_id), 32'h1);
    step();
    chk("irq_addr", imem_addr, 32'h4);
    chk("irq_epc", epc, 32'h14);
    chk("irq_kernel", 32'(kernel_mode), 32'h1);
    step();
    chk("irq_noreentry", imem_addr, 32'h8);
    step();
    chk("irq_noreentry2", imem_addr, 32'hC);
    irq = 1'b0; eret = 1'b1;
    step();
    chk("eret_addr", imem_addr, 32'h14);
    chk("eret_kernel", 32'(kernel_mode), 32'h0);
    idle();
    step(); step(); step();

    // exception and irq together with ID pc4=0x20
    exception = 1'b1; irq = 1'b1;
    step();
    chk("exc_addr", imem_addr, 32'h8);
    chk("exc_epc", epc, 32'h20);
    idle();
    step();

    // sequential wrap past the top of the address space
    jump = 1'b1; jump_target = 32'hFFFF_FFFC;
    step();
    idle();
    step();
    chk("wrap_addr", imem_addr, 32'h0);
    chk("wrap_pc4", if_id_pc4, 32'h0);

    // unaligned target loses its low bits
    jump = 1'b1; jump_target = 32'h43;
    step();
    chk("align_addr", imem_addr, 32'h40);
    idle();

    // random control traffic
    for (int c = 0; c < 800; c++) begin
      reset         = ($urandom_range(0, 99) < 2);
      stall         = ($urandom_range(0, 99) < 20);
      branch_taken  = ($urandom_range(0, 99) < 10);
      jump          = ($urandom_range(0, 99) < 6);
      jr            = ($urandom_range(0, 99) < 5);
      eret          = ($urandom_range(0, 99) < 8);
      exception     = ($urandom_range(0, 99) < 3);
      if ($urandom_range(0, 99) < 12) irq = ~irq;
      branch_target = $urandom();
      jump_target   = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 255)) : $urandom();
      jr_target     = $urandom();
      step();
    end

    idle();
    step();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
